// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo counter: default sizes, per-edge action
// encoding and the wrap/saturate mode values.
package mod_counter_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_PRESC_W = 4;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [1:0] {
        ACT_IDLE = 2'd0,
        ACT_STEP = 2'd1,
        ACT_LOAD = 2'd2,
        ACT_CLR  = 2'd3
    } action_e;

    // Clear beats load, load beats a prescaler tick.
    function automatic action_e select_action(input logic clr, input logic load, input logic tick);
        if (clr)
            return ACT_CLR;
        else if (load)
            return ACT_LOAD;
        else if (tick)
            return ACT_STEP;
        else
            return ACT_IDLE;
    endfunction

endpackage

// File: rtl/mod_counter_prescale.sv
// Prescaler for the modulo counter: emits one tick every div+1 enabled cycles
// and restarts its phase on clear or load.
module mod_counter_prescale
    import mod_counter_pkg::*;
#(
    parameter int PRESC_W = DEFAULT_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr_or_load,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] phase;

    // Greater-or-equal so that lowering div below the current phase ticks at once.
    assign tick = en && (phase >= div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (clr_or_load) begin
            phase <= '0;
        end else if (en) begin
            phase <= tick ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo counter with direction, wrap/saturate mode, clear, load,
// prescaler, terminal-count pulse and sticky overflow flag.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int PRESC_W = DEFAULT_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               up,
    input  logic               sat,
    input  logic               clr,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   limit,
    input  logic [PRESC_W-1:0] div,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               ovf
);

    logic             tick;
    action_e          action;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             ovf_next;

    mod_counter_prescale #(
        .PRESC_W(PRESC_W)
    ) u_prescale (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr_or_load(clr || load),
        .div        (div),
        .tick       (tick)
    );

    always_comb begin
        action     = select_action(clr, load, tick);
        count_next = count;
        tc_next    = 1'b0;
        ovf_next   = ovf;
        case (action)
            ACT_CLR: begin
                count_next = '0;
                ovf_next   = 1'b0;
            end
            ACT_LOAD: begin
                count_next = (load_val > limit) ? limit : load_val;
            end
            ACT_STEP: begin
                if (up) begin
                    if (count < limit) begin
                        count_next = count + 1'b1;
                    end else begin
                        count_next = (sat == MODE_WRAP) ? '0 : limit;
                        tc_next    = 1'b1;
                        ovf_next   = 1'b1;
                    end
                end else begin
                    // A count stranded above a lowered limit snaps back to it.
                    if (count == '0) begin
                        count_next = (sat == MODE_SAT) ? '0 : limit;
                        tc_next    = 1'b1;
                        ovf_next   = 1'b1;
                    end else if (count > limit) begin
                        count_next = limit;
                    end else begin
                        count_next = count - 1'b1;
                    end
                end
            end
            default: begin
                count_next = count;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= tc_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed scenarios plus a randomized
// run compared against a behavioural model of the counting rules.
module tb_mod_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       sat;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] limit;
    logic [3:0] div;
    logic [7:0] count;
    logic       tc;
    logic       ovf;

    int total;
    int bad;

    int m_count;
    int m_pre;
    int m_tc;
    int m_ovf;

    mod_counter #(
        .WIDTH  (8),
        .PRESC_W(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .sat     (sat),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .limit   (limit),
        .div     (div),
        .count   (count),
        .tc      (tc),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model works in plain integers from the behavioural rules, then the edge is taken.
    task automatic tick_clk();
        int  nc;
        int  np;
        int  nt;
        int  no;
        int  lim;
        bit  tk;
        lim = int'(limit);
        nc  = m_count;
        np  = m_pre;
        nt  = 0;
        no  = m_ovf;
        tk  = 1'b0;
        if (!rst) begin
            nc = 0;
            np = 0;
            no = 0;
        end else begin
            if (clr || load) begin
                np = 0;
            end else if (en) begin
                if (m_pre >= int'(div)) begin
                    tk = 1'b1;
                    np = 0;
                end else begin
                    np = m_pre + 1;
                end
            end
            if (clr) begin
                nc = 0;
                no = 0;
            end else if (load) begin
                nc = (int'(load_val) > lim) ? lim : int'(load_val);
            end else if (tk) begin
                if (up) begin
                    if (m_count < lim) begin
                        nc = m_count + 1;
                    end else begin
                        nc = sat ? lim : 0;
                        nt = 1;
                        no = 1;
                    end
                end else begin
                    if (m_count == 0) begin
                        nc = sat ? 0 : lim;
                        nt = 1;
                        no = 1;
                    end else if (m_count > lim) begin
                        nc = lim;
                    end else begin
                        nc = m_count - 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        m_count = nc;
        m_pre   = np;
        m_tc    = nt;
        m_ovf   = no;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        en       = 1'b1;
        up       = 1'b1;
        sat      = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 8'd0;
        limit    = 8'd255;
        div      = 4'd0;
        m_count  = 0;
        m_pre    = 0;
        m_tc     = 0;
        m_ovf    = 0;
        #1;
        total++;
        if (count !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_initial got count=%0d tc=%0b ovf=%0b exp 0/0/0", count, tc, ovf);
        end
        tick_clk();
        total++;
        if (count !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_held got count=%0d tc=%0b ovf=%0b exp 0/0/0", count, tc, ovf);
        end
        rst = 1'b1;
    endtask

    task automatic test_legacy();
        int exp_c;
        total++;
        if (count !== 8'd0) begin
            bad++;
            $display("FAIL legacy_start got=%0d exp=0", count);
        end
        for (int i = 1; i <= 257; i++) begin
            tick_clk();
            exp_c = i % 256;
            total++;
            if (count !== exp_c[7:0] || tc !== (i == 256) || ovf !== (i >= 256)) begin
                bad++;
                $display("FAIL legacy_seq step=%0d got count=%0d tc=%0b ovf=%0b exp count=%0d tc=%0b ovf=%0b",
                         i, count, tc, ovf, exp_c, (i == 256), (i >= 256));
            end
        end
    endtask

    task automatic test_modulo_wrap();
        int exp_c;
        int tc_seen;
        clr = 1'b1;
        tick_clk();
        clr   = 1'b0;
        limit = 8'd9;
        tc_seen = 0;
        for (int i = 1; i <= 11; i++) begin
            tick_clk();
            exp_c = i % 10;
            if (tc === 1'b1) tc_seen++;
            total++;
            if (count !== exp_c[7:0] || tc !== (i == 10)) begin
                bad++;
                $display("FAIL modulo_seq step=%0d got count=%0d tc=%0b exp count=%0d tc=%0b",
                         i, count, tc, exp_c, (i == 10));
            end
        end
        total++;
        if (tc_seen != 1 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL modulo_events got tc_pulses=%0d ovf=%0b exp 1/1", tc_seen, ovf);
        end
        clr = 1'b1;
        tick_clk();
        clr = 1'b0;
        total++;
        if (count !== 8'd0 || ovf !== 1'b0 || tc !== 1'b0) begin
            bad++;
            $display("FAIL modulo_clear got count=%0d ovf=%0b tc=%0b exp 0/0/0", count, ovf, tc);
        end
    endtask

    task automatic test_saturate_down();
        int exp_c[5]   = '{2, 1, 0, 0, 0};
        bit exp_tc[5]  = '{0, 0, 0, 1, 1};
        load_val = 8'd3;
        load     = 1'b1;
        tick_clk();
        load = 1'b0;
        total++;
        if (count !== 8'd3 || tc !== 1'b0) begin
            bad++;
            $display("FAIL satdown_load got count=%0d tc=%0b exp 3/0", count, tc);
        end
        up  = 1'b0;
        sat = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick_clk();
            total++;
            if (count !== exp_c[i][7:0] || tc !== exp_tc[i] || ovf !== (i >= 3)) begin
                bad++;
                $display("FAIL satdown_seq step=%0d got count=%0d tc=%0b ovf=%0b exp count=%0d tc=%0b ovf=%0b",
                         i, count, tc, ovf, exp_c[i], exp_tc[i], (i >= 3));
            end
        end
    endtask

    task automatic test_prescaler();
        int exp_c;
        int exp_pause[6] = '{2, 2, 2, 2, 2, 3};
        up    = 1'b1;
        sat   = 1'b0;
        limit = 8'd255;
        div   = 4'd3;
        clr   = 1'b1;
        tick_clk();
        clr = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick_clk();
            exp_c = k / 4;
            total++;
            if (count !== exp_c[7:0]) begin
                bad++;
                $display("FAIL presc_rate edge=%0d got=%0d exp=%0d", k, count, exp_c);
            end
        end
        for (int k = 0; k < 6; k++) begin
            en = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            tick_clk();
            total++;
            if (count !== exp_pause[k][7:0]) begin
                bad++;
                $display("FAIL presc_pause edge=%0d got=%0d exp=%0d", k, count, exp_pause[k]);
            end
        end
        en  = 1'b1;
        div = 4'd0;
    endtask

    task automatic test_priority();
        clr      = 1'b1;
        load     = 1'b1;
        load_val = 8'd77;
        tick_clk();
        total++;
        if (count !== 8'd0) begin
            bad++;
            $display("FAIL prio_clr_load got=%0d exp=0", count);
        end
        clr      = 1'b0;
        load_val = 8'd200;
        limit    = 8'd100;
        tick_clk();
        total++;
        if (count !== 8'd100) begin
            bad++;
            $display("FAIL prio_clamp got=%0d exp=100", count);
        end
        en       = 1'b0;
        load_val = 8'd50;
        tick_clk();
        load = 1'b0;
        en   = 1'b1;
        total++;
        if (count !== 8'd50) begin
            bad++;
            $display("FAIL prio_load_no_en got=%0d exp=50", count);
        end
    endtask

    task automatic test_limit_zero();
        limit = 8'd0;
        up    = 1'b1;
        sat   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            total++;
            if (count !== 8'd0 || tc !== 1'b1) begin
                bad++;
                $display("FAIL limit_zero step=%0d got count=%0d tc=%0b exp 0/1", i, count, tc);
            end
        end
    endtask

    task automatic test_async_reset();
        limit    = 8'd57;
        load_val = 8'd57;
        load     = 1'b1;
        tick_clk();
        load = 1'b0;
        sat  = 1'b1;
        tick_clk();
        total++;
        if (count !== 8'd57 || tc !== 1'b1 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL areset_setup got count=%0d tc=%0b ovf=%0b exp 57/1/1", count, tc, ovf);
        end
        #2;
        rst = 1'b0;
        m_count = 0;
        m_pre   = 0;
        m_tc    = 0;
        m_ovf   = 0;
        #1;
        total++;
        if (count !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL areset_async got count=%0d tc=%0b ovf=%0b exp 0/0/0", count, tc, ovf);
        end
        tick_clk();
        rst   = 1'b1;
        limit = 8'd255;
        sat   = 1'b0;
        tick_clk();
        total++;
        if (count !== 8'd1) begin
            bad++;
            $display("FAIL areset_resume got=%0d exp=1", count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            up       = $urandom_range(0, 1);
            sat      = $urandom_range(0, 1);
            clr      = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 24) == 0);
            load_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0)
                limit = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            if ($urandom_range(0, 29) == 0)
                div = 4'($urandom_range(0, 3));
            tick_clk();
            total++;
            if (int'(count) != m_count || int'(tc) != m_tc || int'(ovf) != m_ovf) begin
                bad++;
                $display("FAIL random cyc=%0d got count=%0d tc=%0b ovf=%0b exp count=%0d tc=%0d ovf=%0d",
                         i, count, tc, ovf, m_count, m_tc, m_ovf);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_legacy();
        test_modulo_wrap();
        test_saturate_down();
        test_prescaler();
        test_priority();
        test_limit_zero();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised successor to the free-running 8-bit counter.
- Features: configurable width, programmable modulo limit, up/down direction, wrap or saturate mode, synchronous clear and load, built-in prescaler, terminal-count pulse and sticky overflow flag.
- Used as a generic timebase/event counter by generated designs and their testbenches.
- With WIDTH=8, limit=255, div=0, up=1, sat=0 and en=1, it reproduces the legacy count sequence exactly.

Parameters:
- WIDTH, 8: counter width in bits.
- PRESC_W, 4: prescaler divisor width in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- en  in  1  count enable; gates prescaler and counter.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat  in  1  mode: 1 = saturate at bounds, 0 = wrap.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load.
- load_val  in  WIDTH  load value.
- limit  in  WIDTH  upper bound; count range is 0..limit.
- div  in  PRESC_W  prescale divisor; one step per div+1 enabled cycles.
- count  out  WIDTH  current count, driven directly from register.
- tc  out  1  registered terminal-count pulse.
- ovf  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (rst=0): immediately, with no clock edge needed, count=0, prescaler=0, tc=0, ovf=0. Reset applied mid-operation discards all state.
- Priority per edge: rst > clr > load > step.
- clr=1: count=0, prescaler=0, ovf=0, tc=0.
- load=1 (clr=0): count = min(load_val, limit), prescaler=0, tc=0; ovf unchanged. load is honoured regardless of en.
- Prescaler:
  - en=0: prescaler holds its value and no step occurs.
  - en=1 and prescaler==div: tick=1, prescaler returns to 0.
  - en=1 otherwise: prescaler increments.
  - div=0 gives a tick every enabled cycle.
  - div changed mid-period: the compare uses the new value. If prescaler > div, the next enabled cycle ticks and the prescaler returns to 0.
- Step (tick=1, no clr/load):
  - up=1, count<limit: count+1.
  - up=1, count>=limit: sat=0 gives count=0 (wrap event); sat=1 gives count=limit (block event).
  - up=0, count>0: count-1. If count>limit, count=limit.
  - up=0, count==0: sat=0 gives count=limit (wrap event); sat=1 holds at 0 (block event).
- Events:
  - Any wrap or block event sets tc=1 in the next cycle (one cycle per event) and sets ovf=1.
  - tc is 0 in all other cycles.
  - ovf holds 1 until clr or rst.
- Latency: count, tc and ovf change one clock after the qualifying edge inputs. No combinational path from inputs to outputs.
- limit=0: count stays 0. Every step is an event: with sat=0, tc is high every tick cycle.
- limit lowered below the current count: no immediate change. The next up-step is treated as count>=limit; the next down-step loads limit.
- Arithmetic is modulo 2^WIDTH internally. The limit compare prevents any natural overflow.

Decomposition:
- Shared package/include holds:
  - default WIDTH and PRESC_W;
  - the priority encoding constants (CLR, LOAD, STEP);
  - mode constants MODE_WRAP=0 and MODE_SAT=1.
- One natural sub-module, mod_counter_prescale:
  - inputs: clk, rst, en, clr_or_load, div;
  - output: tick;
  - owns the prescaler register.
- The parent holds count, tc and ovf plus the next-count logic.

Test Plan:
- Legacy sequence: WIDTH=8, limit=255, div=0, up=1, sat=0, en=1; release rst. Count must read 0,1,2,…,255,0. tc must be high for exactly the one cycle after 255→0, and ovf=1 from then on.
- Modulo wrap: limit=9. Count must read 0..9,0,1. tc must pulse once per wrap. Then clr=1 for one cycle: count=0, ovf=0.
- Saturate down: load_val=3, load=1, then up=0, sat=1. Count must read 3,2,1,0,0,0. tc must be high on each blocked cycle (2 cycles), and ovf=1.
- Prescaler: div=3. Count must advance once every 4 cycles. Drop en for 2 cycles mid-period: the phase must be preserved, so the next step is delayed by exactly 2 cycles.
- Priority/clamp:
  - clr=1, load=1, en=1 on the same edge: count=0.
  - load_val=200 with limit=100: count=100.
- Asynchronous reset: assert rst=0 between clock edges while count=57. Count, tc and ovf must go to 0 before the next edge. Counting resumes from 0 after release.
